// File: rtl/sprite_pkg.sv
// +--------------------------------------------------------------------------+
// | sprite_pkg: shared types and priority helper for sprite_multi_addr_gen     |
// | Rev 1.0 | optional feature macro: SPRITE_MIRROR_EN                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package sprite_pkg;

  localparam int COORD_W_DEFAULT = 10;
  localparam int COORD_MAX_W     = 16;
  localparam int MAX_SPR         = 16;
  localparam int MAX_ID_W        = 4;

  // Positions are held at the widest supported coordinate width, zero-extended.
  typedef struct packed {
    logic [COORD_MAX_W-1:0] posx;
    logic [COORD_MAX_W-1:0] posy;
    logic                   vis;
`ifdef SPRITE_MIRROR_EN
    logic                   flip;
`endif
  } spr_pos_t;

  function automatic logic [MAX_ID_W-1:0] prio_lowest(input logic [MAX_SPR-1:0] hits);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SPR - 1; i >= 0; i--) begin
      if (hits[i]) begin
        idx = MAX_ID_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_multi_addr_gen_if.sv
// +--------------------------------------------------------------------------+
// | sprite_multi_addr_gen_if: register-write, pixel and result bus            |
// | Rev 1.0 | optional feature macro: SPRITE_MIRROR_EN                         |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sprite_multi_addr_gen_if #(
  parameter int COORD_W    = 10,
  parameter int SPR_W_LOG2 = 6,
  parameter int SPR_H_LOG2 = 6,
  parameter int NUM_SPR    = 4
);

  localparam int ID_W   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int ADDR_W = SPR_H_LOG2 + SPR_W_LOG2;

  logic               frame_start;
  logic               wr_en;
  logic [ID_W-1:0]    wr_idx;
  logic [COORD_W-1:0] wr_posx;
  logic [COORD_W-1:0] wr_posy;
  logic               wr_vis;
`ifdef SPRITE_MIRROR_EN
  logic               wr_flip;
`endif
  logic               pix_valid;
  logic [COORD_W-1:0] pixelx;
  logic [COORD_W-1:0] pixely;
  logic               out_valid;
  logic               out_hit;
  logic [ID_W-1:0]    out_id;
  logic [ADDR_W-1:0]  out_address;

  modport master (
`ifdef SPRITE_MIRROR_EN
    output wr_flip,
`endif
    output frame_start, wr_en, wr_idx, wr_posx, wr_posy, wr_vis,
    output pix_valid, pixelx, pixely,
    input  out_valid, out_hit, out_id, out_address
  );

  modport slave (
`ifdef SPRITE_MIRROR_EN
    input  wr_flip,
`endif
    input  frame_start, wr_en, wr_idx, wr_posx, wr_posy, wr_vis,
    input  pix_valid, pixelx, pixely,
    output out_valid, out_hit, out_id, out_address
  );

endinterface

`default_nettype wire

// File: rtl/sprite_hit_cell.sv
// +--------------------------------------------------------------------------+
// | sprite_hit_cell: per-channel stage-1 bounds test and in-sprite offset     |
// | Rev 1.0 | optional feature macro: SPRITE_MIRROR_EN                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module sprite_hit_cell
  import sprite_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int SPR_W_LOG2 = 6,
  parameter int SPR_H_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  spr_pos_t              pos,
  input  logic [COORD_W-1:0]    pixelx,
  input  logic [COORD_W-1:0]    pixely,
  output logic                  hit,
  output logic [SPR_W_LOG2-1:0] col,
  output logic [SPR_H_LOG2-1:0] row
);

  localparam int DW = COORD_MAX_W + 1;
  localparam logic [DW-2:0] c_spr_w = (DW-1)'(1 << SPR_W_LOG2);
  localparam logic [DW-2:0] c_spr_h = (DW-1)'(1 << SPR_H_LOG2);

  logic [DW-1:0]         dx;
  logic [DW-1:0]         dy;
  logic                  hit_d, hit_q;
  logic [SPR_W_LOG2-1:0] col_d, col_q;
  logic [SPR_H_LOG2-1:0] row_d, row_q;

  // Both operands are below 2**COORD_W, so the wider subtraction yields the
  // same sign bit and magnitude as a COORD_W+1 bit one.
  always_comb begin
    dx    = {1'b0, COORD_MAX_W'(pixelx)} - {1'b0, pos.posx};
    dy    = {1'b0, COORD_MAX_W'(pixely)} - {1'b0, pos.posy};
    hit_d = pos.vis
          & ~dx[DW-1] & (dx[DW-2:0] < c_spr_w)
          & ~dy[DW-1] & (dy[DW-2:0] < c_spr_h);
    col_d = dx[SPR_W_LOG2-1:0];
    row_d = dy[SPR_H_LOG2-1:0];
`ifdef SPRITE_MIRROR_EN
    if (pos.flip) begin
      col_d = ~dx[SPR_W_LOG2-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      hit_q <= hit_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign hit = hit_q;
  assign col = col_q;
  assign row = row_q;

endmodule

`default_nettype wire

// File: rtl/sprite_multi_addr_gen.sv
// +--------------------------------------------------------------------------+
// | sprite_multi_addr_gen: multi-sprite, double-buffered, 2-stage ROM address |
// | Rev 1.0 | optional feature macro: SPRITE_MIRROR_EN                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module sprite_multi_addr_gen
  import sprite_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEFAULT,
  parameter int SPR_W_LOG2 = 6,
  parameter int SPR_H_LOG2 = 6,
  parameter int NUM_SPR    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sprite_multi_addr_gen_if.slave bus
);

  localparam int ID_W   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int ADDR_W = SPR_H_LOG2 + SPR_W_LOG2;

  spr_pos_t shadow_q [NUM_SPR];
  spr_pos_t shadow_d [NUM_SPR];
  spr_pos_t active_q [NUM_SPR];
  spr_pos_t active_d [NUM_SPR];
  spr_pos_t wr_pos;

  logic                  valid1_q, valid1_d;
  logic [NUM_SPR-1:0]    hit_vec;
  logic [SPR_W_LOG2-1:0] col_arr [NUM_SPR];
  logic [SPR_H_LOG2-1:0] row_arr [NUM_SPR];

  logic [ID_W-1:0]   win;
  logic              out_valid_q, out_valid_d;
  logic              out_hit_q, out_hit_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ADDR_W-1:0] out_address_q, out_address_d;

  // Active takes the shadow as it stands after this cycle's write, so a
  // write coinciding with frame_start lands in active immediately.
  always_comb begin
    wr_pos      = '0;
    wr_pos.posx = COORD_MAX_W'(bus.wr_posx);
    wr_pos.posy = COORD_MAX_W'(bus.wr_posy);
    wr_pos.vis  = bus.wr_vis;
`ifdef SPRITE_MIRROR_EN
    wr_pos.flip = bus.wr_flip;
`endif
    for (int i = 0; i < NUM_SPR; i++) begin
      shadow_d[i] = shadow_q[i];
      if (bus.wr_en && (int'(bus.wr_idx) == i)) begin
        shadow_d[i] = wr_pos;
      end
      active_d[i] = bus.frame_start ? shadow_d[i] : active_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign valid1_d = bus.pix_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid1_q <= 1'b0;
    end else begin
      valid1_q <= valid1_d;
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_cell
    sprite_hit_cell #(
      .COORD_W    (COORD_W),
      .SPR_W_LOG2 (SPR_W_LOG2),
      .SPR_H_LOG2 (SPR_H_LOG2)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .pos    (active_q[g]),
      .pixelx (bus.pixelx),
      .pixely (bus.pixely),
      .hit    (hit_vec[g]),
      .col    (col_arr[g]),
      .row    (row_arr[g])
    );
  end

  always_comb begin
    win           = ID_W'(prio_lowest(MAX_SPR'(hit_vec)));
    out_valid_d   = valid1_q;
    out_hit_d     = valid1_q & (|hit_vec);
    out_id_d      = '0;
    out_address_d = '0;
    if (out_hit_d) begin
      out_id_d      = win;
      out_address_d = {row_arr[win], col_arr[win]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_hit_q     <= 1'b0;
      out_id_q      <= '0;
      out_address_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_hit_q     <= out_hit_d;
      out_id_q      <= out_id_d;
      out_address_q <= out_address_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_hit     = out_hit_q;
  assign bus.out_id      = out_id_q;
  assign bus.out_address = out_address_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_multi_addr_gen.sv
// +--------------------------------------------------------------------------+
// | tb_sprite_multi_addr_gen: directed table plus randomized model checking   |
// | Rev 1.0 | optional feature macro: SPRITE_MIRROR_EN                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_multi_addr_gen;

  localparam int COORD_W    = 10;
  localparam int SPR_W_LOG2 = 6;
  localparam int SPR_H_LOG2 = 6;
  localparam int NUM_SPR    = 4;
  localparam int SW         = 1 << SPR_W_LOG2;
  localparam int SH         = 1 << SPR_H_LOG2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_multi_addr_gen_if #(
    .COORD_W(COORD_W), .SPR_W_LOG2(SPR_W_LOG2), .SPR_H_LOG2(SPR_H_LOG2), .NUM_SPR(NUM_SPR)
  ) bus ();

  sprite_multi_addr_gen #(
    .COORD_W(COORD_W), .SPR_W_LOG2(SPR_W_LOG2), .SPR_H_LOG2(SPR_H_LOG2), .NUM_SPR(NUM_SPR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: sprite rectangles in plain integer arithmetic.
  int m_sx [NUM_SPR], m_sy [NUM_SPR], m_sv [NUM_SPR], m_sf [NUM_SPR];
  int m_ax [NUM_SPR], m_ay [NUM_SPR], m_av [NUM_SPR], m_af [NUM_SPR];
  int s1_v, s1_h, s1_id, s1_a;
  int s2_v, s2_h, s2_id, s2_a;

  typedef struct {
    bit wr; int idx; int x; int y; bit vis; bit flip;
    bit fs; bit pv; int px; int py;
    bit chk; bit ev; bit eh; int eid; int ea;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    int h, id, a, px, py, c;
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        m_sx[i] = 0; m_sy[i] = 0; m_sv[i] = 0; m_sf[i] = 0;
        m_ax[i] = 0; m_ay[i] = 0; m_av[i] = 0; m_af[i] = 0;
      end
      s1_v = 0; s1_h = 0; s1_id = 0; s1_a = 0;
      s2_v = 0; s2_h = 0; s2_id = 0; s2_a = 0;
      return;
    end
    s2_v = s1_v; s2_h = s1_h; s2_id = s1_id; s2_a = s1_a;
    h = 0; id = 0; a = 0;
    px = int'(bus.pixelx);
    py = int'(bus.pixely);
    if (bus.pix_valid) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        if (h == 0 && m_av[i] != 0 && px >= m_ax[i] && px < m_ax[i] + SW
            && py >= m_ay[i] && py < m_ay[i] + SH) begin
          h  = 1;
          id = i;
          c  = px - m_ax[i];
          if (m_af[i] != 0) c = SW - 1 - c;
          a  = (py - m_ay[i]) * SW + c;
        end
      end
    end
    s1_v = bus.pix_valid ? 1 : 0; s1_h = h; s1_id = id; s1_a = a;
    if (bus.wr_en && int'(bus.wr_idx) < NUM_SPR) begin
      m_sx[bus.wr_idx] = int'(bus.wr_posx);
      m_sy[bus.wr_idx] = int'(bus.wr_posy);
      m_sv[bus.wr_idx] = bus.wr_vis ? 1 : 0;
`ifdef SPRITE_MIRROR_EN
      m_sf[bus.wr_idx] = bus.wr_flip ? 1 : 0;
`endif
    end
    if (bus.frame_start) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_av[i] = m_sv[i]; m_af[i] = m_sf[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_valid", 32'(bus.out_valid), 32'(s2_v));
    chk("model_hit", 32'(bus.out_hit), 32'(s2_h));
    chk("model_id", 32'(bus.out_id), 32'(s2_id));
    chk("model_addr", 32'(bus.out_address), 32'(s2_a));
  endtask

  task automatic drive(input vec_t v);
    bus.wr_en       = v.wr;
    bus.wr_idx      = 2'(v.idx);
    bus.wr_posx     = 10'(v.x);
    bus.wr_posy     = 10'(v.y);
    bus.wr_vis      = v.vis;
`ifdef SPRITE_MIRROR_EN
    bus.wr_flip     = v.flip;
`endif
    bus.frame_start = v.fs;
    bus.pix_valid   = v.pv;
    bus.pixelx      = 10'(v.px);
    bus.pixely      = 10'(v.py);
  endtask

  function automatic vec_t f_idle();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  function automatic vec_t f_wr(int idx, int x, int y, bit vis, bit flip);
    vec_t v;
    v = f_idle();
    v.wr = 1; v.idx = idx; v.x = x; v.y = y; v.vis = vis; v.flip = flip;
    return v;
  endfunction

  function automatic vec_t f_fs();
    vec_t v;
    v = f_idle();
    v.fs = 1;
    return v;
  endfunction

  function automatic vec_t f_pix(int px, int py, bit eh, int eid, int ea);
    vec_t v;
    v = f_idle();
    v.pv = 1; v.px = px; v.py = py;
    v.chk = 1; v.ev = 1; v.eh = eh; v.eid = eid; v.ea = ea;
    return v;
  endfunction

  initial begin
    vec_t v;
    drive(f_idle());
    rst_n = 1'b0;
    bus.pix_valid = 1'b1;

    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_addr", 32'(bus.out_address), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("idle_invisible_hit", 32'(bus.out_hit), 32'd0);

    vecs.push_back(f_wr(0, 100, 50, 1, 0));
    vecs.push_back(f_fs());
    vecs.push_back(f_pix(163, 113, 1, 0, 12'hFFF));
    vecs.push_back(f_pix(164, 113, 0, 0, 0));
    vecs.push_back(f_pix(99, 50, 0, 0, 0));
    vecs.push_back(f_pix(100, 113, 1, 0, 63 * SW));
    vecs.push_back(f_pix(100, 114, 0, 0, 0));
    vecs.push_back(f_wr(0, 200, 200, 1, 0));
    vecs.push_back(f_pix(100, 50, 1, 0, 0));
    vecs.push_back(f_fs());
    vecs.push_back(f_pix(100, 50, 0, 0, 0));
    vecs.push_back(f_pix(200, 200, 1, 0, 0));
    vecs.push_back(f_wr(1, 10, 10, 1, 0));
    vecs.push_back(f_wr(2, 20, 20, 1, 0));
    vecs.push_back(f_fs());
    vecs.push_back(f_pix(30, 30, 1, 1, 20 * SW + 20));
    vecs.push_back(f_wr(1, 10, 10, 0, 0));
    vecs.push_back(f_fs());
    vecs.push_back(f_pix(30, 30, 1, 2, 10 * SW + 10));
    vecs.push_back(f_wr(0, 1000, 0, 1, 0));
    vecs.push_back(f_fs());
    vecs.push_back(f_pix(1023, 5, 1, 0, 5 * SW + 23));
    v = f_wr(0, 0, 0, 1, 0);
    v.fs = 1; v.pv = 1; v.px = 0; v.py = 0;
    v.chk = 1; v.ev = 1; v.eh = 0; v.eid = 0; v.ea = 0;
    vecs.push_back(v);
    vecs.push_back(f_pix(0, 0, 1, 0, 0));
    v = f_pix(0, 0, 0, 0, 0);
    v.pv = 0; v.ev = 0;
    vecs.push_back(v);
`ifdef SPRITE_MIRROR_EN
    vecs.push_back(f_wr(0, 0, 0, 1, 1));
    vecs.push_back(f_fs());
    vecs.push_back(f_pix(3, 2, 1, 0, 2 * SW + 60));
`endif
    vecs.push_back(f_idle());
    vecs.push_back(f_idle());

    for (int j = 0; j < vecs.size(); j++) begin
      if (j >= 2 && vecs[j-2].chk) begin
        chk($sformatf("tbl%0d_valid", j-2), 32'(bus.out_valid), 32'(vecs[j-2].ev));
        chk($sformatf("tbl%0d_hit", j-2), 32'(bus.out_hit), 32'(vecs[j-2].eh));
        chk($sformatf("tbl%0d_id", j-2), 32'(bus.out_id), 32'(vecs[j-2].eid));
        chk($sformatf("tbl%0d_addr", j-2), 32'(bus.out_address), 32'(vecs[j-2].ea));
      end
      drive(vecs[j]);
      tick();
    end

    // Reset in the middle of a stream of hitting pixels must flush both stages.
    drive(f_pix(5, 5, 1, 0, 0));
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid0", 32'(bus.out_valid), 32'd0);
    chk("midrst_hit0", 32'(bus.out_hit), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_valid1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("postrst_valid", 32'(bus.out_valid), 32'd1);
    chk("postrst_hit", 32'(bus.out_hit), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      v = f_idle();
      v.wr   = ($urandom_range(0, 3) == 0);
      v.idx  = $urandom_range(0, NUM_SPR - 1);
      v.vis  = ($urandom_range(0, 3) != 0);
      v.flip = $urandom_range(0, 1);
      v.fs   = ($urandom_range(0, 7) == 0);
      v.pv   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        v.x  = $urandom_range(960, 1023);
        v.y  = $urandom_range(960, 1023);
        v.px = $urandom_range(960, 1023);
        v.py = $urandom_range(960, 1023);
      end else begin
        v.x  = $urandom_range(0, 255);
        v.y  = $urandom_range(0, 255);
        v.px = $urandom_range(0, 330);
        v.py = $urandom_range(0, 330);
      end
      drive(v);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive(f_idle());
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_multi_addr_gen.md
Name: sprite_multi_addr_gen

Overview:
- Parametrised, pipelined successor to the single-sprite address generator.
- Serves NUM_SPR sprites of configurable power-of-two size.
- Sprite positions are double-buffered and committed only at frame start, so there is no mid-frame tearing.
- For each incoming pixel it outputs the ROM address, sprite id and hit flag of the highest-priority sprite covering that pixel. Sits between the VGA timing generator and the sprite ROM mux.

Parameters:
- COORD_W, 10, width of pixel and position coordinates.
- SPR_W_LOG2, 6, log2 of sprite width in pixels.
- SPR_H_LOG2, 6, log2 of sprite height in pixels.
- NUM_SPR, 4, number of sprite channels (1..16).
- ID_W, (NUM_SPR>1 ? $clog2(NUM_SPR) : 1), sprite index width (derived, not overridden).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- frame_start  in  1  one-cycle pulse; commits shadow registers to active.
- wr_en  in  1  shadow register write strobe.
- wr_idx  in  ID_W  channel written.
- wr_posx  in  COORD_W  new x position.
- wr_posy  in  COORD_W  new y position.
- wr_vis  in  1  channel visible flag.
- pix_valid  in  1  pixelx/pixely valid this cycle.
- pixelx  in  COORD_W  current pixel x.
- pixely  in  COORD_W  current pixel y.
- out_valid  out  1  result valid (pix_valid delayed 2).
- out_hit  out  1  some visible sprite covers the pixel.
- out_id  out  ID_W  winning channel index.
- out_address  out  SPR_H_LOG2+SPR_W_LOG2  {row, col} address into the winning sprite.

Behaviour:
- Reset (rst_n=0 at clk edge): all shadow and active posx/posy/vis cleared to 0, pipeline valids cleared. On the following cycle out_valid=0, out_hit=0, out_id=0, out_address=0.
- Reset mid-frame flushes both pipeline stages; no stale result is ever emitted.
- Shadow write: on wr_en, shadow[wr_idx] gets {wr_posx, wr_posy, wr_vis}. A wr_idx >= NUM_SPR is ignored.
- Commit: on frame_start, active gets shadow for all channels simultaneously.
- If wr_en and frame_start coincide, active receives the newly written value for wr_idx; all other channels get their current shadow values.
- Active registers change only on frame_start or reset.
- Stage 1 (registered), per channel:
  - dx = {1'b0,pixelx} - {1'b0,posx} and dy likewise, computed in COORD_W+1 bits.
  - hit_c = vis & ~dx[MSB] & (dx[COORD_W-1:0] < 2**SPR_W_LOG2) & ~dy[MSB] & (dy[COORD_W-1:0] < 2**SPR_H_LOG2).
  - Store hit_c and the low SPR bits of dx/dy.
  - No wrap-around aliasing: a pixel left of or above the sprite never hits.
  - A sprite extending past the screen edge simply clips.
- Stage 2 (registered): fixed priority, lowest index wins.
  - out_hit = OR of all hit_c.
  - out_id = lowest hit index.
  - out_address = {dy_w[SPR_H_LOG2-1:0], dx_w[SPR_W_LOG2-1:0]} of the winner.
  - When there is no hit, out_id=0 and out_address=0.
- Latency is exactly 2 cycles from pix_valid/pixel to out_*.
- Throughput is one pixel per cycle with no stalls.
- When pix_valid=0, out_valid=0 two cycles later, and out_hit is also forced 0.
- A frame_start in the same cycle as a pixel: that pixel uses the pre-commit active values; the next pixel uses the new ones.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- When defined:
  - Adds input port wr_flip (1 bit), stored in shadow/active per channel alongside position.
  - For a flipped winner, the column field becomes (2**SPR_W_LOG2-1) - dx_w; the row is unchanged.
  - Reset clears flip.
- When undefined: no port, no storage, column always dx_w.

Decomposition:
- Package sprite_pkg: COORD_W default, a typedef for sprite position (struct of posx, posy, vis, and flip under the macro), and the priority-select function.
- One natural sub-module: sprite_hit_cell (per-channel stage-1 bounds/offset compute), instantiated NUM_SPR times via generate.

Test Plan:
1. Reset then idle: rst_n low 2 cycles, pix_valid=1, pixel (0,0) -> out_valid/out_hit/out_address all 0 while in reset; sprites invisible after reset -> out_hit=0.
2. Single sprite:
   - Write ch0 pos (100,50), vis=1, then pulse frame_start.
   - Pixel (163,113) -> 2 cycles later out_hit=1, out_id=0, out_address=12'hFFF.
   - Pixel (164,113) -> out_hit=0.
   - Pixel (99,50) -> out_hit=0 (no wrap).
3. Double buffering: write ch0 pos (200,200) without frame_start; pixel (100,50) still hits; after frame_start pixel (100,50) -> hit=0, pixel (200,200) -> hit=1, address 0.
4. Priority: ch1 at (10,10) and ch2 at (20,20), both visible; pixel (30,30) -> out_id=1, out_address={6'd20,6'd20}; set ch1 vis=0 and commit -> out_id=2, address {6'd10,6'd10}.
5. Edge clip and coincidence:
   - ch0 at (1000,0); pixel (1023,5) -> hit, address {6'd5,6'd23}.
   - wr_en and frame_start in the same cycle moving ch0 to (0,0) -> the next pixel (0,0) hits.
6. SPRITE_MIRROR_EN: ch0 at (0,0) with flip=1; pixel (3,2) -> out_address={6'd2,6'd60}.
